// File: rtl/soc_evt_fifo_pkg.sv
// Shared constants and width helpers for the multi-channel event FIFO.
package soc_evt_fifo_pkg;

  localparam int OVF_CNT_W = 16;

  typedef logic [OVF_CNT_W-1:0] ovf_cnt_t;

  function automatic int chan_idx_w(input int nb_chan);
    return (nb_chan > 1) ? $clog2(nb_chan) : 1;
  endfunction

  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/soc_evt_fifo_chan.sv
// One event channel: register-array FIFO with fill, push pulse and overflow flag.
// The drop counter exists only when SOC_EVT_FIFO_OVF_CNT_EN is defined.
module soc_evt_fifo_chan
  import soc_evt_fifo_pkg::*;
#(
  parameter int EVNT_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic [EVNT_WIDTH-1:0]         data_i,
  input  logic                          pop_req_i,
  input  logic                          clear_i,
  output logic                          full_o,
  output logic                          pop_valid_o,
  output logic [EVNT_WIDTH-1:0]         pop_data_o,
  output logic                          pulse_o,
  output logic [fill_w(FIFO_DEPTH)-1:0] fill_o,
  output logic                          ovf_o,
  output ovf_cnt_t                      ovf_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [EVNT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_fill;
  logic                  r_pulse;
  logic                  r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_drop;

  assign w_full    = (r_fill == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_fill == '0);
  // Clear wins over everything; a full channel never bypasses a same-cycle pop.
  assign w_push_ok = push_i && !clear_i && !w_full;
  assign w_drop    = (DROP_ON_FULL != 0) && push_i && !clear_i && w_full;
  assign w_pop_ok  = pop_req_i && !clear_i && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_pulse  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_pulse  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_pulse <= w_push_ok;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_fill <= r_fill + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_fill <= r_fill - 1'b1;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef SOC_EVT_FIFO_OVF_CNT_EN
  ovf_cnt_t r_ovf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (clear_i) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt_o = r_ovf_cnt;
`else
  assign ovf_cnt_o = '0;
`endif

  assign full_o      = w_full;
  assign pop_valid_o = !w_empty;
  assign pop_data_o  = r_mem[r_rd_ptr];
  assign pulse_o     = r_pulse;
  assign fill_o      = r_fill;
  assign ovf_o       = r_ovf;

endmodule

// File: rtl/soc_evt_fifo_mc.sv
// Multi-channel event FIFO: push demux in front of NB_CHAN independent channels.
// Define SOC_EVT_FIFO_OVF_CNT_EN to build the per-channel saturating drop counters.
module soc_evt_fifo_mc
  import soc_evt_fifo_pkg::*;
#(
  parameter int NB_CHAN      = 4,
  parameter int EVNT_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       evt_valid_i,
  output logic                                       evt_ready_o,
  input  logic [EVNT_WIDTH-1:0]                      evt_data_i,
  input  logic [chan_idx_w(NB_CHAN)-1:0]             evt_chan_i,
  input  logic [NB_CHAN-1:0]                         pop_req_i,
  output logic [NB_CHAN-1:0]                         pop_valid_o,
  output logic [NB_CHAN-1:0][EVNT_WIDTH-1:0]         pop_data_o,
  input  logic [NB_CHAN-1:0]                         clear_i,
  output logic [NB_CHAN-1:0]                         evt_pulse_o,
  output logic [NB_CHAN-1:0][fill_w(FIFO_DEPTH)-1:0] fill_o,
  output logic [NB_CHAN-1:0]                         ovf_o,
  output logic [NB_CHAN-1:0][OVF_CNT_W-1:0]          ovf_cnt_o
);

  localparam int CW = chan_idx_w(NB_CHAN);

  logic [NB_CHAN-1:0] w_sel;
  logic [NB_CHAN-1:0] w_full;
  logic [NB_CHAN-1:0] w_push;
  logic               w_accept;

  // An out-of-range channel selects nothing, so it is accepted and silently discarded.
  assign evt_ready_o = !rst_i && ((DROP_ON_FULL != 0) || !(|(w_sel & w_full)));
  assign w_accept    = evt_valid_i && evt_ready_o;

  for (genvar gi = 0; gi < NB_CHAN; gi++) begin : g_chan
    assign w_sel[gi]  = (evt_chan_i == CW'(gi));
    assign w_push[gi] = w_accept && w_sel[gi];

    soc_evt_fifo_chan #(
      .EVNT_WIDTH   (EVNT_WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .DROP_ON_FULL (DROP_ON_FULL)
    ) u_chan (
      .clk         (clk_i),
      .rst         (rst_i),
      .push_i      (w_push[gi]),
      .data_i      (evt_data_i),
      .pop_req_i   (pop_req_i[gi]),
      .clear_i     (clear_i[gi]),
      .full_o      (w_full[gi]),
      .pop_valid_o (pop_valid_o[gi]),
      .pop_data_o  (pop_data_o[gi]),
      .pulse_o     (evt_pulse_o[gi]),
      .fill_o      (fill_o[gi]),
      .ovf_o       (ovf_o[gi]),
      .ovf_cnt_o   (ovf_cnt_o[gi])
    );
  end

endmodule

// File: tb/tb_soc_evt_fifo_mc.sv
// Bench: backpressure and drop-on-full instances driven identically, checked against queue models.
module tb_soc_evt_fifo_mc;

  localparam int NB    = 5;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          evt_valid = 1'b0;
  logic [7:0]    evt_data = '0;
  logic [2:0]    evt_chan = '0;
  logic [NB-1:0] pop_req = '0;
  logic [NB-1:0] clear = '0;

  logic                 rdy   [2];
  logic [NB-1:0]        pv    [2];
  logic [NB-1:0][7:0]   pd    [2];
  logic [NB-1:0]        pulse [2];
  logic [NB-1:0][3:0]   fill  [2];
  logic [NB-1:0]        ovf   [2];
  logic [NB-1:0][15:0]  cnt   [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [2][NB][$];
  bit         mo [2][NB];
  int         mc [2][NB];
  bit         mp [2][NB];

  always #5 clk = ~clk;

  soc_evt_fifo_mc #(.NB_CHAN(NB), .EVNT_WIDTH(8), .FIFO_DEPTH(DEPTH), .DROP_ON_FULL(0)) u_dut_bp (
    .clk_i(clk), .rst_i(rst), .evt_valid_i(evt_valid), .evt_ready_o(rdy[0]),
    .evt_data_i(evt_data), .evt_chan_i(evt_chan), .pop_req_i(pop_req),
    .pop_valid_o(pv[0]), .pop_data_o(pd[0]), .clear_i(clear), .evt_pulse_o(pulse[0]),
    .fill_o(fill[0]), .ovf_o(ovf[0]), .ovf_cnt_o(cnt[0])
  );

  soc_evt_fifo_mc #(.NB_CHAN(NB), .EVNT_WIDTH(8), .FIFO_DEPTH(DEPTH), .DROP_ON_FULL(1)) u_dut_drop (
    .clk_i(clk), .rst_i(rst), .evt_valid_i(evt_valid), .evt_ready_o(rdy[1]),
    .evt_data_i(evt_data), .evt_chan_i(evt_chan), .pop_req_i(pop_req),
    .pop_valid_o(pv[1]), .pop_data_o(pd[1]), .clear_i(clear), .evt_pulse_o(pulse[1]),
    .fill_o(fill[1]), .ovf_o(ovf[1]), .ovf_cnt_o(cnt[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NB; c++) begin
        mq[d][c].delete();
        mo[d][c] = 1'b0;
        mc[d][c] = 0;
        mp[d][c] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [NB-1:0]       e_pv, e_pl, e_ov;
    logic [NB-1:0][3:0]  e_f;
    logic [NB-1:0][7:0]  e_pd, m_pd;
    logic [NB-1:0][15:0] e_c;
    int n;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NB; c++) begin
        n       = mq[d][c].size();
        e_f[c]  = 4'(n);
        e_pv[c] = (n != 0);
        e_pd[c] = (n != 0) ? mq[d][c][0] : 8'h00;
        m_pd[c] = (n != 0) ? 8'hFF : 8'h00;
        e_pl[c] = mp[d][c];
        e_ov[c] = mo[d][c];
`ifdef SOC_EVT_FIFO_OVF_CNT_EN
        e_c[c]  = 16'(mc[d][c]);
`else
        e_c[c]  = 16'h0000;
`endif
      end
      chk($sformatf("fill%0d", d), 128'(fill[d]), 128'(e_f));
      chk($sformatf("pop_valid%0d", d), 128'(pv[d]), 128'(e_pv));
      chk($sformatf("pop_data%0d", d), 128'(pd[d] & m_pd), 128'(e_pd));
      chk($sformatf("pulse%0d", d), 128'(pulse[d]), 128'(e_pl));
      chk($sformatf("ovf%0d", d), 128'(ovf[d]), 128'(e_ov));
      chk($sformatf("ovf_cnt%0d", d), 128'(cnt[d]), 128'(e_c));
    end
  endtask

  // One clock cycle of stimulus; the model is advanced from the pre-edge state.
  task automatic step(input logic v, input logic [7:0] dat, input logic [2:0] ch,
                      input logic [NB-1:0] pop, input logic [NB-1:0] clr);
    bit er [2];
    int n;
    evt_valid = v; evt_data = dat; evt_chan = ch; pop_req = pop; clear = clr;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 1 || int'(ch) >= NB) er[d] = 1'b1;
      else er[d] = (mq[d][ch].size() != DEPTH);
      chk($sformatf("ready%0d", d), 128'(rdy[d]), 128'(er[d]));
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NB; c++) begin
        mp[d][c] = 1'b0;
        if (clr[c]) begin
          mq[d][c].delete();
          mo[d][c] = 1'b0;
          mc[d][c] = 0;
        end else begin
          n = mq[d][c].size();
          if (pop[c] && n > 0) void'(mq[d][c].pop_front());
          if (v && er[d] && int'(ch) == c) begin
            if (n == DEPTH) begin
              mo[d][c] = 1'b1;
              if (mc[d][c] < 65535) mc[d][c]++;
            end else begin
              mq[d][c].push_back(dat);
              mp[d][c] = 1'b1;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    evt_valid = 1'b0; pop_req = '0; clear = '0;
    check_all();
  endtask

  task automatic do_reset();
    evt_valid = 1'b1; evt_data = 8'hC3; evt_chan = 3'd0;
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 128'(rdy[d]), 128'(0));
      chk($sformatf("rst_pop_valid%0d", d), 128'(pv[d]), 128'(0));
      chk($sformatf("rst_pulse%0d", d), 128'(pulse[d]), 128'(0));
      chk($sformatf("rst_fill%0d", d), 128'(fill[d]), 128'(0));
      chk($sformatf("rst_ovf%0d", d), 128'(ovf[d]), 128'(0));
      chk($sformatf("rst_ovf_cnt%0d", d), 128'(cnt[d]), 128'(0));
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    evt_valid = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] p, cl;
    logic [15:0]   exp_cnt;
`ifdef SOC_EVT_FIFO_OVF_CNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("init_ready%0d", d), 128'(rdy[d]), 128'(0));
      chk($sformatf("init_fill%0d", d), 128'(fill[d]), 128'(0));
      chk($sformatf("init_pop_valid%0d", d), 128'(pv[d]), 128'(0));
    end
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // In-order delivery on channel 2
    step(1'b1, 8'h11, 3'd2, '0, '0);
    step(1'b1, 8'h22, 3'd2, '0, '0);
    step(1'b1, 8'h33, 3'd2, '0, '0);
    chk("ord_fill", 128'(fill[0][2]), 128'(3));
    chk("ord_head", 128'(pd[0][2]), 128'(8'h11));
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 3'd0, NB'(4), '0);
    chk("ord_empty", 128'(fill[0][2]), 128'(0));

    // Fill channel 0, ninth push: backpressure vs drop
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 3'd0, '0, '0);
    chk("full_fill", 128'(fill[0][0]), 128'(8));
    step(1'b1, 8'h99, 3'd0, '0, '0);
    chk("ninth_ovf_drop", 128'(ovf[1][0]), 128'(1));
    step(1'b0, 8'h00, 3'd0, NB'(1), '0);
    step(1'b1, 8'h99, 3'd0, '0, '0);
    chk("ninth_stored_fill", 128'(fill[0][0]), 128'(8));
    step(1'b0, 8'h00, 3'd0, '0, NB'(1));

    // Ten pushes to channel 1: two dropped on the drop instance, then clear
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 3'd1, '0, '0);
    chk("ovf_flag", 128'(ovf[1][1]), 128'(1));
    chk("ovf_count", 128'(cnt[1][1]), 128'(exp_cnt));
    chk("bp_no_ovf", 128'(ovf[0][1]), 128'(0));
    step(1'b0, 8'h00, 3'd0, '0, NB'(2));
    chk("clr_ovf", 128'(ovf[1][1]), 128'(0));

    // Clear beats a same-cycle push; out-of-range channel is discarded
    step(1'b1, 8'h77, 3'd1, '0, NB'(2));
    step(1'b1, 8'h88, 3'd6, '0, '0);
    step(1'b1, 8'h89, 3'd5, '0, '0);

    // Simultaneous push and pop on channel 3
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 3'd3, '0, '0);
    step(1'b1, 8'hAA, 3'd3, NB'(8), '0);
    chk("pp_fill", 128'(fill[0][3]), 128'(4));
    step(1'b0, 8'h00, 3'd0, '0, NB'(8));
    step(1'b1, 8'hBB, 3'd3, NB'(8), '0);
    chk("pp_empty_fill", 128'(fill[0][3]), 128'(1));
    chk("pp_empty_valid", 128'(pv[0][3]), 128'(1));

    // Reset mid-push with data in channel 0
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD0 + i), 3'd0, '0, '0);
    do_reset();
    check_all();
    step(1'b1, 8'h5A, 3'd0, '0, '0);
    chk("post_rst_head", 128'(pd[0][0]), 128'(8'h5A));

    // Random traffic: a filling phase with rare pops, then a draining phase
    for (int i = 0; i < 600; i++) begin
      if (i < 300) p = NB'($urandom) & NB'($urandom) & NB'($urandom) & NB'($urandom);
      else         p = NB'($urandom) & NB'($urandom);
      cl = ($urandom_range(0, 63) == 0) ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
      step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom_range(0, 6)), p, cl);
      if (i == 450) begin
        do_reset();
        check_all();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
